// File: rtl/div_result_collector_pkg.sv
// div_result_collector_pkg: shared FSM state, beat-select constants and record sizing for the divider result path
package div_result_collector_pkg;
  typedef enum logic {IDLE, GOT_Q} state_t;
  localparam logic SEL_QUOT = 1'b0;
  localparam logic SEL_REM  = 1'b1;
  function automatic int rec_bits(input int w);
    return 2 * w + 2;
  endfunction
endpackage

// File: rtl/div_result_collector_if.sv
// div_result_collector_if: divider result bus in (res_bus/done/selOut/OV/DivByZero), record stream out (out_*), start gating and sticky flags
interface div_result_collector_if #(parameter int WIDTH = 6);
  logic [WIDTH-1:0] res_bus;
  logic             done;
  logic             selOut;
  logic             OV;
  logic             DivByZero;
  logic             div_start_ok;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quot;
  logic [WIDTH-1:0] out_rem;
  logic             out_ov;
  logic             out_dbz;
  logic             overrun;
  logic             proto_err;
  modport master (
    output res_bus, done, selOut, OV, DivByZero, out_ready,
    input  div_start_ok, out_valid, out_quot, out_rem, out_ov, out_dbz, overrun, proto_err
  );
  modport slave (
    input  res_bus, done, selOut, OV, DivByZero, out_ready,
    output div_start_ok, out_valid, out_quot, out_rem, out_ov, out_dbz, overrun, proto_err
  );
endinterface

// File: rtl/div_result_collector_fifo.sv
// result_fifo: DEPTH x W sync FIFO; push/din in, pop in, dout (entry at rptr), count/full/empty, dropped when push hits full without pop
module result_fifo #(
  parameter int W     = 14,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       dropped
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dropped = push & ~do_push;
  assign dout    = mem[rptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/div_result_collector.sv
// div_result_collector: assembles quotient/remainder beats and error pulses from bus into records, queues them, gates div_start_ok
module div_result_collector
  import div_result_collector_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DEPTH = 2
) (
  input logic                  clk,
  input logic                  rst,
  div_result_collector_if.slave bus
);
  typedef struct packed {
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             ov;
    logic             dbz;
  } rec_t;
  localparam int CW = $clog2(DEPTH + 1);
  state_t           state;
  logic [WIDTH-1:0] q_hold;
  rec_t             rec, head;
  logic             err, rem_beat, push, dropped, full, empty, overrun, proto_err;
  logic [CW-1:0]    count;
  assign err      = bus.OV | bus.DivByZero;
  assign rem_beat = bus.done & (bus.selOut == SEL_REM);
  assign push     = err | (state == GOT_Q & rem_beat);
  assign rec      = err ? rec_t'{quot: '0, rem: '0, ov: bus.OV, dbz: bus.DivByZero}
                        : rec_t'{quot: q_hold, rem: bus.res_bus, ov: 1'b0, dbz: 1'b0};
  result_fifo #(.W(rec_bits(WIDTH)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (bus.out_valid & bus.out_ready),
    .din     (rec),
    .dout    (head),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .dropped (dropped)
  );
  // a held quotient reserves a slot, so one free slot is not enough while in GOT_Q
  assign bus.div_start_ok = ~full & ~(state == GOT_Q & count == CW'(DEPTH - 1));
  assign bus.out_valid    = ~empty;
  assign bus.out_quot     = head.quot;
  assign bus.out_rem      = head.rem;
  assign bus.out_ov       = head.ov;
  assign bus.out_dbz      = head.dbz;
  assign bus.overrun      = overrun;
  assign bus.proto_err    = proto_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      q_hold    <= '0;
      overrun   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      overrun <= overrun | dropped;
      if (err) state <= IDLE;
      else if (bus.done && bus.selOut == SEL_QUOT) begin
        q_hold <= bus.res_bus;
        state  <= GOT_Q;
      end else if (bus.done) begin
        proto_err <= proto_err | (state == IDLE);
        state     <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_div_result_collector.sv
// tb_div_result_collector: directed vectors with hand-computed expectations for div_result_collector
module tb_div_result_collector;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  always #5 clk = ~clk;
  div_result_collector_if #(.WIDTH(6)) bus ();
  div_result_collector #(.WIDTH(6), .DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic sel, input logic [5:0] v);
    bus.done = 1'b1;
    bus.selOut = sel;
    bus.res_bus = v;
    step();
    bus.done = 1'b0;
  endtask
  task automatic pulse(input logic ov, input logic dbz);
    bus.OV = ov;
    bus.DivByZero = dbz;
    step();
    bus.OV = 1'b0;
    bus.DivByZero = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  initial begin
    bus.res_bus = '0;
    bus.done = 1'b0;
    bus.selOut = 1'b0;
    bus.OV = 1'b0;
    bus.DivByZero = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    step();
    do_reset();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_quot", bus.out_quot, 0);
    chk("rst_rem", bus.out_rem, 0);
    chk("rst_flags", {bus.out_ov, bus.out_dbz, bus.overrun, bus.proto_err}, 0);
    chk("rst_start_ok", bus.div_start_ok, 1);
    bus.out_ready = 1'b1;
    beat(1'b0, 6'd5);
    chk("n_start_ok_gotq_cnt0", bus.div_start_ok, 1);
    beat(1'b1, 6'd3);
    chk("n_valid", bus.out_valid, 1);
    chk("n_quot", bus.out_quot, 5);
    chk("n_rem", bus.out_rem, 3);
    chk("n_ovdbz", {bus.out_ov, bus.out_dbz}, 0);
    step();
    chk("n_popped", bus.out_valid, 0);
    pulse(1'b0, 1'b1);
    chk("dbz_valid", bus.out_valid, 1);
    chk("dbz_qr", {bus.out_quot, bus.out_rem}, 0);
    chk("dbz_flags", {bus.out_ov, bus.out_dbz}, 1);
    step();
    pulse(1'b1, 1'b0);
    chk("ov_valid", bus.out_valid, 1);
    chk("ov_flags", {bus.out_ov, bus.out_dbz}, 2);
    step();
    chk("ov_popped", bus.out_valid, 0);
    bus.out_ready = 1'b0;
    beat(1'b0, 6'd5);
    beat(1'b1, 6'd3);
    chk("bp_start_ok_cnt1_idle", bus.div_start_ok, 1);
    beat(1'b0, 6'd7);
    chk("bp_start_ok_cnt1_gotq", bus.div_start_ok, 0);
    beat(1'b1, 6'd1);
    chk("bp_start_ok_full", bus.div_start_ok, 0);
    chk("bp_overrun_pre", bus.overrun, 0);
    beat(1'b0, 6'd2);
    beat(1'b1, 6'd2);
    chk("bp_overrun", bus.overrun, 1);
    chk("bp_head_quot", bus.out_quot, 5);
    chk("bp_head_rem", bus.out_rem, 3);
    bus.out_ready = 1'b1;
    step();
    chk("bp_2nd_valid", bus.out_valid, 1);
    chk("bp_2nd_quot", bus.out_quot, 7);
    chk("bp_2nd_rem", bus.out_rem, 1);
    step();
    chk("bp_drained", bus.out_valid, 0);
    do_reset();
    bus.out_ready = 1'b0;
    beat(1'b0, 6'd1);
    beat(1'b1, 6'd1);
    beat(1'b0, 6'd2);
    beat(1'b1, 6'd2);
    beat(1'b0, 6'd3);
    chk("sp_start_ok", bus.div_start_ok, 0);
    bus.out_ready = 1'b1;
    beat(1'b1, 6'd3);
    chk("sp_valid", bus.out_valid, 1);
    chk("sp_overrun", bus.overrun, 0);
    chk("sp_head_quot", bus.out_quot, 2);
    chk("sp_head_rem", bus.out_rem, 2);
    step();
    chk("sp_wrap_valid", bus.out_valid, 1);
    chk("sp_wrap_quot", bus.out_quot, 3);
    chk("sp_wrap_rem", bus.out_rem, 3);
    step();
    chk("sp_drained", bus.out_valid, 0);
    do_reset();
    bus.out_ready = 1'b1;
    beat(1'b1, 6'd9);
    chk("pe_proto_err", bus.proto_err, 1);
    chk("pe_no_record", bus.out_valid, 0);
    beat(1'b0, 6'd9);
    beat(1'b0, 6'd4);
    beat(1'b1, 6'd1);
    chk("pe_restart_valid", bus.out_valid, 1);
    chk("pe_restart_quot", bus.out_quot, 4);
    chk("pe_restart_rem", bus.out_rem, 1);
    step();
    bus.out_ready = 1'b0;
    beat(1'b0, 6'd5);
    beat(1'b1, 6'd3);
    beat(1'b0, 6'd6);
    do_reset();
    chk("mr_valid", bus.out_valid, 0);
    chk("mr_flags", {bus.overrun, bus.proto_err}, 0);
    chk("mr_start_ok", bus.div_start_ok, 1);
    beat(1'b1, 6'd7);
    chk("mr_proto_err", bus.proto_err, 1);
    chk("mr_no_record", bus.out_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/div_result_collector.md
Name: div_result_collector

Overview:
- Sits directly downstream of the sequential divider datapath and its controller.
- Captures the two-beat serialized result (quotient beat, then remainder beat, both qualified by done/selOut) from the shared result bus.
- Captures the one-cycle OV/DivByZero error pulses.
- Assembles each operation into one record, buffers it in a small FIFO, and presents it to the consumer over a valid/ready handshake.
- Drives div_start_ok back upstream so a new division is only launched when a result slot is guaranteed.

Parameters:
- WIDTH, 6, width of quotient/remainder beats on res_bus.
- DEPTH, 2, number of result records buffered; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- res_bus  in  WIDTH  divider result bus; quotient when selOut=0, remainder when selOut=1.
- done  in  1  result beat valid on res_bus.
- selOut  in  1  beat select: 0=quotient, 1=remainder.
- OV  in  1  overflow pulse, one cycle, never coincident with done.
- DivByZero  in  1  divide-by-zero pulse, one cycle.
- div_start_ok  out  1  high when a new division may be started.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts head record.
- out_quot  out  WIDTH  head record quotient.
- out_rem  out  WIDTH  head record remainder.
- out_ov  out  1  head record overflow flag.
- out_dbz  out  1  head record divide-by-zero flag.
- overrun  out  1  sticky: a record was dropped because the FIFO was full.
- proto_err  out  1  sticky: remainder beat arrived without a preceding quotient beat.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State to IDLE; FIFO count, read pointer and write pointer to 0.
  - out_valid=0, out_quot/out_rem=0, out_ov=out_dbz=0, overrun=0, proto_err=0, div_start_ok=1.
  - Reset mid-assembly discards the partial record.
- Assembly FSM, two states:
  - IDLE, done&~selOut: latch res_bus into q_hold, go to GOT_Q.
  - IDLE, done&selOut: ignore beat, set proto_err, stay in IDLE.
  - IDLE, OV|DivByZero: push record {quot=0, rem=0, ov=OV, dbz=DivByZero}, stay in IDLE.
  - GOT_Q, done&selOut: push record {q_hold, res_bus, 0, 0}, go to IDLE.
  - GOT_Q, done&~selOut: overwrite q_hold (a new operation has restarted), stay in GOT_Q.
  - GOT_Q, OV|DivByZero: drop the partial record, push the error record, go to IDLE.
  - GOT_Q, no beat: stay in GOT_Q indefinitely.
- FIFO:
  - DEPTH entries, each holding {quot, rem, ov, dbz}.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count ranges 0..DEPTH.
- Push/pop rules:
  - A push writes at wptr, increments wptr and count.
  - A pop occurs when out_valid&out_ready; it increments rptr and decrements count.
  - Simultaneous push and pop: both happen and count is unchanged. This is allowed even when count=DEPTH (pop frees the slot in the same cycle).
  - Push with count=DEPTH and no pop: record dropped, overrun set, pointers unchanged.
  - Pop with count=0: impossible because out_valid=0.
- Outputs:
  - out_valid = (count != 0).
  - out_quot/out_rem/out_ov/out_dbz are the entry at rptr; they are registered-FIFO read data.
  - They are held stable while out_valid&~out_ready.
  - When out_valid=0 they show the last-read entry (don't-care for checking).
- Latency:
  - A record pushed at edge N gives out_valid=1 after edge N, i.e. one cycle after the remainder beat or error pulse is sampled.
  - With an empty FIFO and out_ready=1 the record is popped at edge N+1.
- div_start_ok = (count + (state==GOT_Q)) < DEPTH, computed combinationally from registered state.
  - Upstream holds start low while it is 0; if upstream violates this, overrun catches the loss.
- Sticky flags: overrun and proto_err clear only on rst.

Decomposition:
- Shared package holds:
  - the result record struct {quot, rem, ov, dbz} parameterised by WIDTH;
  - the FSM state enum (IDLE, GOT_Q);
  - the beat-select constants SEL_QUOT=0, SEL_REM=1, also usable by the divider controller.
- One natural sub-module: result_fifo (generic DEPTH x record-width synchronous FIFO with count, full/empty, simultaneous push/pop).
- The collector instantiates result_fifo plus the assembly FSM and q_hold register.

Test Plan:
- Normal result, 23/4: done,selOut=0,res_bus=5 then done,selOut=1,res_bus=3 with out_ready=1.
  - Required: one cycle later out_valid=1, quot=5, rem=3, ov=dbz=0; popped next edge; div_start_ok=0 during GOT_Q only when count=1.
- Divide-by-zero: DivByZero pulse one cycle.
  - Required: out_valid=1 next cycle with quot=0, rem=0, dbz=1, ov=0; separately an OV pulse gives ov=1.
- Backpressure/full: out_ready=0, three complete results (5/3, 7/1, 2/2).
  - Required: first two buffered in order; div_start_ok=0 after the second; third dropped; overrun=1.
  - Then out_ready=1: records 5/3 and 7/1 emerge in order.
- Simultaneous push/pop at full: count=2, out_ready=1 in the same cycle as a remainder beat.
  - Required: count stays 2, no overrun, FIFO order preserved across pointer wrap.
- Protocol errors:
  - Remainder beat while IDLE: proto_err=1, no record.
  - Two quotient beats (9 then 4) then remainder 1: record quot=4, rem=1.
- Reset mid-operation: rst after quotient beat with one record queued.
  - Required: next cycle out_valid=0, all flags 0, div_start_ok=1; a later remainder beat sets proto_err=1 and pushes nothing.
